// File: rtl/ip_psram_arbiter.sv
// Two-requester arbiter in front of one ip_psram channel. Each port latches one request,
// one transaction runs at a time, and a watchdog forces completion of stuck waits.
module ip_psram_arbiter #(
   parameter int ADDR_W     = 22,
   parameter int TIMEOUT    = 255,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic              r0_rd,
   input  logic              r0_wr,
   input  logic [ADDR_W-1:0] r0_address,
   input  logic [7:0]        r0_wdata,
   output logic              r0_busy,
   output logic [7:0]        r0_rdata,
   output logic              r0_rdata_en,
   input  logic              r1_rd,
   input  logic              r1_wr,
   input  logic [ADDR_W-1:0] r1_address,
   input  logic [7:0]        r1_wdata,
   output logic              r1_busy,
   output logic [7:0]        r1_rdata,
   output logic              r1_rdata_en,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_address,
   output logic [7:0]        mem_wdata,
   input  logic              mem_busy,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_rdata_en,
   output logic              active_port,
   output logic              timeout_err
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_RD   = 3'd2,
      ST_WR_SETTLE = 3'd3,
      ST_WAIT_WR   = 3'd4
   } state_t;

   // Watchdog fires on the TIMEOUT-th wait cycle (counter starts at 0 on the first one).
   localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

   function automatic logic pick_port(input logic [1:0] pend, input logic last);
      logic port;
      if (pend == 2'b11) begin
         port = FIXED_PRIO ? 1'b0 : ~last;
      end else if (pend[1]) begin
         port = 1'b1;
      end else begin
         port = 1'b0;
      end
      return port;
   endfunction

   state_t            state_r, state_nx_s;
   logic [1:0]        pend_r, op_rd_r, req_rd_s, req_wr_s, rdata_en_r;
   logic [ADDR_W-1:0] addr_r [2];
   logic [ADDR_W-1:0] addr_in_s [2];
   logic [7:0]        wdata_r [2];
   logic [7:0]        wdata_in_s [2];
   logic [7:0]        rdata_r [2];
   logic              mem_rd_r, mem_wr_r;
   logic [ADDR_W-1:0] mem_address_r;
   logic [7:0]        mem_wdata_r;
   logic              active_r, last_r, timeout_err_r;
   logic [15:0]       wd_cnt_r;
   logic              grant_s, grant_port_s, done_s, done_rd_s, to_s, wd_hit_s;
   logic [7:0]        done_data_s;

   assign req_rd_s      = {r1_rd, r0_rd};
   assign req_wr_s      = {r1_wr, r0_wr};
   assign addr_in_s[0]  = r0_address;
   assign addr_in_s[1]  = r1_address;
   assign wdata_in_s[0] = r0_wdata;
   assign wdata_in_s[1] = r1_wdata;
   assign wd_hit_s      = (wd_cnt_r == WD_LAST);

   // Per-port request capture; a port's pending slot clears when its transaction completes.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         pend_r  <= 2'b00;
         op_rd_r <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            addr_r[i]  <= {ADDR_W{1'b0}};
            wdata_r[i] <= 8'h00;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (done_s && (active_r == i[0])) begin
               pend_r[i] <= 1'b0;
            end else if (!pend_r[i] && (req_rd_s[i] || req_wr_s[i])) begin
               pend_r[i]  <= 1'b1;
               op_rd_r[i] <= req_rd_s[i];
               addr_r[i]  <= addr_in_s[i];
               wdata_r[i] <= wdata_in_s[i];
            end else begin
               pend_r[i] <= pend_r[i];
            end
         end
      end
   end

   // Transaction state register.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state, grant and completion decode.
   always_comb begin
      state_nx_s   = state_r;
      grant_s      = 1'b0;
      grant_port_s = active_r;
      done_s       = 1'b0;
      done_rd_s    = 1'b0;
      done_data_s  = 8'h00;
      to_s         = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if ((pend_r != 2'b00) && !mem_busy) begin
               grant_s      = 1'b1;
               grant_port_s = pick_port(pend_r, last_r);
               state_nx_s   = ST_ISSUE;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (op_rd_r[active_r]) begin
               state_nx_s = ST_WAIT_RD;
            end else begin
               state_nx_s = ST_WR_SETTLE;
            end
         end
         ST_WAIT_RD: begin
            if (mem_rdata_en) begin
               done_s      = 1'b1;
               done_rd_s   = 1'b1;
               done_data_s = mem_rdata;
               state_nx_s  = ST_IDLE;
            end else if (wd_hit_s) begin
               done_s      = 1'b1;
               done_rd_s   = 1'b1;
               done_data_s = 8'hFF;
               to_s        = 1'b1;
               state_nx_s  = ST_IDLE;
            end else begin
               state_nx_s = ST_WAIT_RD;
            end
         end
         ST_WR_SETTLE: begin
            if (wd_hit_s) begin
               done_s     = 1'b1;
               to_s       = 1'b1;
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_WAIT_WR;
            end
         end
         ST_WAIT_WR: begin
            if (!mem_busy) begin
               done_s     = 1'b1;
               state_nx_s = ST_IDLE;
            end else if (wd_hit_s) begin
               done_s     = 1'b1;
               to_s       = 1'b1;
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_WAIT_WR;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // Memory-side request pulse, held address/data and grant pointer.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         mem_rd_r      <= 1'b0;
         mem_wr_r      <= 1'b0;
         mem_address_r <= {ADDR_W{1'b0}};
         mem_wdata_r   <= 8'h00;
         active_r      <= 1'b0;
         last_r        <= 1'b1;
      end else begin
         mem_rd_r <= grant_s && op_rd_r[grant_port_s];
         mem_wr_r <= grant_s && !op_rd_r[grant_port_s];
         if (grant_s) begin
            mem_address_r <= addr_r[grant_port_s];
            mem_wdata_r   <= wdata_r[grant_port_s];
            active_r      <= grant_port_s;
            last_r        <= grant_port_s;
         end else begin
            mem_address_r <= mem_address_r;
         end
      end
   end

   // Read-data return to the requester that owned the completed read.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         rdata_en_r <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            rdata_r[i] <= 8'h00;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            rdata_en_r[i] <= done_s && done_rd_s && (active_r == i[0]);
            if (done_s && done_rd_s && (active_r == i[0])) begin
               rdata_r[i] <= done_data_s;
            end else begin
               rdata_r[i] <= rdata_r[i];
            end
         end
      end
   end

   // Watchdog counter and sticky timeout flag.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         wd_cnt_r      <= 16'h0000;
         timeout_err_r <= 1'b0;
      end else begin
         if (state_r == ST_ISSUE) begin
            wd_cnt_r <= 16'h0000;
         end else if ((state_r == ST_WAIT_RD) || (state_r == ST_WR_SETTLE) ||
                      (state_r == ST_WAIT_WR)) begin
            wd_cnt_r <= wd_cnt_r + 16'h0001;
         end else begin
            wd_cnt_r <= wd_cnt_r;
         end
         timeout_err_r <= timeout_err_r | to_s;
      end
   end

   assign r0_busy     = pend_r[0];
   assign r1_busy     = pend_r[1];
   assign r0_rdata    = rdata_r[0];
   assign r1_rdata    = rdata_r[1];
   assign r0_rdata_en = rdata_en_r[0];
   assign r1_rdata_en = rdata_en_r[1];
   assign mem_rd      = mem_rd_r;
   assign mem_wr      = mem_wr_r;
   assign mem_address = mem_address_r;
   assign mem_wdata   = mem_wdata_r;
   assign active_port = active_r;
   assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_ip_psram_arbiter.sv
// Directed bench for ip_psram_arbiter: a round-robin and a fixed-priority instance share
// stimulus, and a small ip_psram model answers the round-robin instance's requests.
module tb_ip_psram_arbiter;

   logic        clk;
   logic        n_reset;
   logic        r0_rd, r0_wr, r1_rd, r1_wr;
   logic [21:0] r0_address, r1_address;
   logic [7:0]  r0_wdata, r1_wdata;
   logic        r0_busy, r1_busy, r0_rdata_en, r1_rdata_en;
   logic [7:0]  r0_rdata, r1_rdata;
   logic        mem_rd, mem_wr, mem_busy, mem_rdata_en;
   logic [21:0] mem_address;
   logic [7:0]  mem_wdata, mem_rdata;
   logic        active_port, timeout_err;

   logic        fp_r0_busy, fp_r1_busy, fp_r0_rdata_en, fp_r1_rdata_en;
   logic [7:0]  fp_r0_rdata, fp_r1_rdata, fp_mem_wdata;
   logic        fp_mem_rd, fp_mem_wr, fp_active_port, fp_timeout_err;
   logic [21:0] fp_mem_address;

   int total, bad, cyc, t0, e0, m_rd, m_wr;
   int n_mem_rd, n_mem_wr, n_r0_en, n_r1_en, rd_cyc;
   int rd_cnt, busy_cnt, rd_lat, wr_len;
   logic rd_never, hold, ok;
   logic [7:0] rd_data;
   logic [3:0] gpat, fpat;
   int glog[$];
   int fglog[$];

   ip_psram_arbiter #(.ADDR_W(22), .TIMEOUT(255), .FIXED_PRIO(1'b0)) dut (
      .clk(clk), .n_reset(n_reset),
      .r0_rd(r0_rd), .r0_wr(r0_wr), .r0_address(r0_address), .r0_wdata(r0_wdata),
      .r0_busy(r0_busy), .r0_rdata(r0_rdata), .r0_rdata_en(r0_rdata_en),
      .r1_rd(r1_rd), .r1_wr(r1_wr), .r1_address(r1_address), .r1_wdata(r1_wdata),
      .r1_busy(r1_busy), .r1_rdata(r1_rdata), .r1_rdata_en(r1_rdata_en),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_address(mem_address), .mem_wdata(mem_wdata),
      .mem_busy(mem_busy), .mem_rdata(mem_rdata), .mem_rdata_en(mem_rdata_en),
      .active_port(active_port), .timeout_err(timeout_err));

   ip_psram_arbiter #(.ADDR_W(22), .TIMEOUT(255), .FIXED_PRIO(1'b1)) dut_fp (
      .clk(clk), .n_reset(n_reset),
      .r0_rd(r0_rd), .r0_wr(r0_wr), .r0_address(r0_address), .r0_wdata(r0_wdata),
      .r0_busy(fp_r0_busy), .r0_rdata(fp_r0_rdata), .r0_rdata_en(fp_r0_rdata_en),
      .r1_rd(r1_rd), .r1_wr(r1_wr), .r1_address(r1_address), .r1_wdata(r1_wdata),
      .r1_busy(fp_r1_busy), .r1_rdata(fp_r1_rdata), .r1_rdata_en(fp_r1_rdata_en),
      .mem_rd(fp_mem_rd), .mem_wr(fp_mem_wr), .mem_address(fp_mem_address),
      .mem_wdata(fp_mem_wdata), .mem_busy(mem_busy), .mem_rdata(mem_rdata),
      .mem_rdata_en(mem_rdata_en), .active_port(fp_active_port), .timeout_err(fp_timeout_err));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample just after the edge, then update pulses and the memory model.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (!hold) begin
         r0_rd = 1'b0; r0_wr = 1'b0; r1_rd = 1'b0; r1_wr = 1'b0;
      end
      if (mem_rd) begin
         n_mem_rd++;
         rd_cyc = cyc;
         glog.push_back(int'(active_port));
         fglog.push_back(int'(fp_active_port));
      end
      if (mem_wr) n_mem_wr++;
      if (r0_rdata_en) n_r0_en++;
      if (r1_rdata_en) n_r1_en++;
      mem_rdata_en = 1'b0;
      mem_busy = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
      if (rd_cnt > 0) begin
         rd_cnt--;
         if (rd_cnt == 0) begin
            mem_rdata_en = 1'b1;
            mem_rdata = rd_data;
         end
      end
      if (mem_rd && !rd_never) begin
         rd_cnt = rd_lat;
         busy_cnt = rd_lat + 2;
      end
      if (mem_wr) busy_cnt = wr_len;
   endtask

   task automatic wait_idle();
      logic idle;
      idle = 1'b0;
      for (int k = 0; k < 60; k++) begin
         if (!mem_busy && !r0_busy && !r1_busy) begin
            idle = 1'b1;
            break;
         end
         tick();
      end
      check("idle_wait", 32'(idle), 32'd1);
   endtask

   task automatic do_reset();
      n_reset = 1'b0;
      hold = 1'b0;
      r0_rd = 1'b0; r0_wr = 1'b0; r1_rd = 1'b0; r1_wr = 1'b0;
      rd_cnt = 0; busy_cnt = 0; rd_never = 1'b0;
      mem_busy = 1'b0; mem_rdata_en = 1'b0;
      tick(); tick();
      n_reset = 1'b1;
      tick();
   endtask

   initial begin
      total = 0; bad = 0; cyc = 0; rd_cyc = 0;
      n_mem_rd = 0; n_mem_wr = 0; n_r0_en = 0; n_r1_en = 0;
      rd_cnt = 0; busy_cnt = 0; rd_lat = 5; wr_len = 8; rd_never = 1'b0; hold = 1'b0;
      rd_data = 8'h00;
      n_reset = 1'b0;
      r0_rd = 1'b0; r0_wr = 1'b0; r1_rd = 1'b0; r1_wr = 1'b0;
      r0_address = 22'h000000; r1_address = 22'h000000; r0_wdata = 8'h00; r1_wdata = 8'h00;
      mem_busy = 1'b0; mem_rdata = 8'h00; mem_rdata_en = 1'b0;

      tick(); tick();
      check("rst_busy", 32'({r1_busy, r0_busy}), 32'd0);
      check("rst_mem_req", 32'({mem_wr, mem_rd}), 32'd0);
      check("rst_mem_addr", 32'(mem_address), 32'd0);
      check("rst_port_err", 32'({timeout_err, active_port}), 32'd0);
      check("rst_rdata", 32'({r1_rdata_en, r0_rdata_en, r1_rdata, r0_rdata}), 32'd0);
      check("rst_fp", 32'({fp_r0_busy, fp_r1_busy, fp_mem_rd, fp_active_port, fp_timeout_err}), 32'd0);
      n_reset = 1'b1;
      tick();

      // 1: basic read on port 0
      wait_idle();
      rd_lat = 5; rd_data = 8'hA5; r0_address = 22'h012345; r0_rd = 1'b1; t0 = cyc;
      tick();
      check("t1_busy_rise", 32'(r0_busy), 32'd1);
      tick();
      check("t1_mem_req", 32'({mem_wr, mem_rd}), 32'd1);
      check("t1_addr", 32'(mem_address), 32'h012345);
      check("t1_port", 32'(active_port), 32'd0);
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (r0_rdata_en) begin ok = 1'b1; break; end
      end
      check("t1_wait", 32'(ok), 32'd1);
      check("t1_lat", 32'(cyc - t0), 32'd8);
      check("t1_rdata", 32'(r0_rdata), 32'hA5);
      check("t1_busy_fall", 32'(r0_busy), 32'd0);
      tick();
      check("t1_en_width", 32'(r0_rdata_en), 32'd0);
      check("t1_no_r1_en", 32'(n_r1_en), 32'd0);

      // 2: write on port 1
      wait_idle();
      wr_len = 8; r1_address = 22'h3FFFFF; r1_wdata = 8'h5A; r1_wr = 1'b1; t0 = cyc; e0 = n_r1_en;
      tick(); tick();
      check("t2_mem_req", 32'({mem_wr, mem_rd}), 32'd2);
      check("t2_wdata", 32'(mem_wdata), 32'h5A);
      check("t2_addr", 32'(mem_address), 32'h3FFFFF);
      check("t2_port", 32'(active_port), 32'd1);
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (!r1_busy) begin ok = 1'b1; break; end
      end
      check("t2_wait", 32'(ok), 32'd1);
      check("t2_lat", 32'(cyc - t0), 32'd12);
      check("t2_no_rdata_en", 32'(n_r1_en - e0), 32'd0);

      // 6: rd+wr together is a read; a pulse while busy is ignored
      wait_idle();
      rd_data = 8'h3C; r0_address = 22'h000100; r0_rd = 1'b1; r0_wr = 1'b1; t0 = cyc;
      m_rd = n_mem_rd; m_wr = n_mem_wr;
      tick();
      check("t6_busy", 32'(r0_busy), 32'd1);
      r0_wr = 1'b1; r0_address = 22'h000200; r0_wdata = 8'hEE;
      tick();
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (r0_rdata_en) begin ok = 1'b1; break; end
      end
      check("t6_wait", 32'(ok), 32'd1);
      check("t6_lat", 32'(cyc - t0), 32'd8);
      check("t6_rdata", 32'(r0_rdata), 32'h3C);
      repeat (10) tick();
      check("t6_rd_pulses", 32'(n_mem_rd - m_rd), 32'd1);
      check("t6_wr_pulses", 32'(n_mem_wr - m_wr), 32'd0);
      check("t6_addr_hold", 32'(mem_address), 32'h000100);

      // 4: read watchdog, then a normal read
      wait_idle();
      rd_never = 1'b1; r0_address = 22'h0000AA; r0_rd = 1'b1;
      tick(); tick();
      check("t4_mem_rd", 32'(mem_rd), 32'd1);
      check("t4_err_clear", 32'(timeout_err), 32'd0);
      ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
         tick();
         if (r0_rdata_en) begin ok = 1'b1; break; end
      end
      check("t4_wait", 32'(ok), 32'd1);
      check("t4_lat", 32'(cyc - rd_cyc), 32'd256);
      check("t4_rdata_ff", 32'(r0_rdata), 32'hFF);
      check("t4_err_set", 32'({timeout_err, r0_busy}), 32'd2);
      rd_never = 1'b0;
      repeat (5) tick();
      check("t4_err_sticky", 32'(timeout_err), 32'd1);
      wait_idle();
      rd_data = 8'h77; r0_address = 22'h001234; r0_rd = 1'b1; t0 = cyc;
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (r0_rdata_en) begin ok = 1'b1; break; end
      end
      check("t4_next_wait", 32'(ok), 32'd1);
      check("t4_next_lat", 32'(cyc - t0), 32'd8);
      check("t4_next_rdata", 32'(r0_rdata), 32'h77);
      check("t4_next_err", 32'(timeout_err), 32'd1);

      // 3: both ports requesting continuously from reset
      do_reset();
      glog.delete(); fglog.delete();
      rd_lat = 5; hold = 1'b1; r0_rd = 1'b1; r1_rd = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         tick();
         if (glog.size() >= 4) begin ok = 1'b1; break; end
      end
      check("t3_wait", 32'(ok), 32'd1);
      gpat = 4'hF; fpat = 4'hF;
      if (glog.size() >= 4 && fglog.size() >= 4) begin
         for (int i = 0; i < 4; i++) begin
            gpat[3-i] = (glog[i] != 0);
            fpat[3-i] = (fglog[i] != 0);
         end
      end
      check("t3_rr_order", 32'(gpat), 32'b0101);
      check("t3_fixed_order", 32'(fpat), 32'b0000);
      check("t3_fixed_starve", 32'(fp_r1_busy), 32'd1);
      hold = 1'b0; r0_rd = 1'b0; r1_rd = 1'b0;
      tick();

      // 5: reset while waiting for read data
      do_reset();
      rd_lat = 10; rd_data = 8'h99; r0_address = 22'h000055; r0_rd = 1'b1; e0 = n_r0_en;
      tick(); tick();
      check("t5_mem_rd", 32'(mem_rd), 32'd1);
      repeat (3) tick();
      n_reset = 1'b0;
      #2;
      check("t5_async_outs", 32'({r0_busy, r1_busy, mem_rd, mem_wr, active_port, timeout_err, r0_rdata_en}), 32'd0);
      check("t5_async_addr", 32'(mem_address), 32'd0);
      tick(); tick();
      n_reset = 1'b1;
      repeat (12) tick();
      check("t5_no_strobe", 32'(n_r0_en - e0), 32'd0);
      check("t5_idle_busy", 32'(r0_busy), 32'd0);
      wait_idle();
      rd_lat = 5; rd_data = 8'hC3; r0_address = 22'h000066; r0_rd = 1'b1; t0 = cyc;
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (r0_rdata_en) begin ok = 1'b1; break; end
      end
      check("t5_fresh_wait", 32'(ok), 32'd1);
      check("t5_fresh_lat", 32'(cyc - t0), 32'd8);
      check("t5_fresh_rdata", 32'(r0_rdata), 32'hC3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
